// File: rtl/imem_uart_loader.sv
// UART byte-stream loader for the writable instruction RAM.
// Assembles framed 32-bit words, writes them, and holds the CPU during a load.
module imem_uart_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK
    } state_t;

    state_t        state, state_next;
    logic [7:0]    len_hi;
    logic [15:0]   len;
    logic [16:0]   word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic [7:0]    chk;
    logic [TW-1:0] tcnt;

    logic [15:0] count;
    logic        too_long;
    logic        last_word;
    logic        timeout;

    assign count     = {len_hi, rx_data};
    assign too_long  = 32'(count) > DEPTH;
    assign last_word = (word_idx + 17'd1) == {1'b0, len};
    assign timeout   = (state != IDLE) && !rx_valid
                       && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (rx_valid) begin
            unique case (state)
                IDLE:    if (rx_data == 8'hA5) state_next = LEN_HI;
                LEN_HI:  state_next = LEN_LO;
                LEN_LO: begin
                    if (too_long)           state_next = IDLE;
                    else if (count == 16'd0) state_next = CHECK;
                    else                    state_next = DATA;
                end
                DATA: begin
                    if (byte_cnt == 2'd3 && last_word) state_next = CHECK;
                end
                CHECK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_hi     <= '0;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            chk        <= '0;
            tcnt       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (state == IDLE || rx_valid || timeout) tcnt <= '0;
            else                                      tcnt <= tcnt + 1'b1;

            if (timeout) begin
                error <= 1'b1;
            end else if (rx_valid) begin
                unique case (state)
                    IDLE: begin
                        if (rx_data == 8'hA5) begin
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            chk      <= '0;
                            word_idx <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    LEN_HI: begin
                        len_hi <= rx_data;
                        chk    <= chk ^ rx_data;
                    end
                    LEN_LO: begin
                        len <= count;
                        chk <= chk ^ rx_data;
                        if (too_long) error <= 1'b1;
                    end
                    DATA: begin
                        chk      <= chk ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {shift, rx_data};
                            imem_addr  <= {13'd0, word_idx, 2'b00};
                            word_idx   <= word_idx + 17'd1;
                        end else begin
                            shift <= {shift[15:0], rx_data};
                        end
                    end
                    CHECK: begin
                        // A failed image keeps the CPU held
                        if (rx_data == chk) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized scoreboard bench for imem_uart_loader.
// Stimulus pushes expected writes; a monitor pops them on each imem_we.
module tb_imem_uart_loader;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_hold, done, error;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    logic exp_done, exp_error, exp_hold;

    imem_uart_loader #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", imem_addr, 32'hFFFFFFFF);
            end else begin
                logic [63:0] e;
                e = wq.pop_front();
                check("write_addr", imem_addr, e[63:32]);
                check("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Reference: frame semantics computed directly from the byte list
    task automatic model(input logic [7:0] f[$]);
        int n;
        logic [7:0] x;
        n = {f[1], f[2]};
        if (n > 256) begin
            exp_done = 0; exp_error = 1; exp_hold = 1;
            return;
        end
        for (int i = 0; i < n; i++)
            wq.push_back({32'(i * 4), f[3+4*i], f[4+4*i],
                          f[5+4*i], f[6+4*i]});
        x = 8'h00;
        for (int i = 1; i < f.size() - 1; i++) x ^= f[i];
        if (x == f[f.size()-1]) begin
            exp_done = 1; exp_error = 0; exp_hold = 0;
        end else begin
            exp_done = 0; exp_error = 1; exp_hold = 1;
        end
    endtask

    task automatic build(input int n, input bit bad,
                         output logic [7:0] f[$]);
        logic [7:0] x;
        f = {8'hA5, 8'(n >> 8), 8'(n)};
        x = f[1] ^ f[2];
        for (int i = 0; i < 4 * n; i++) begin
            f.push_back(8'($urandom));
            x ^= f[$];
        end
        f.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    // gap < 0 selects a random 0..2 idle cycles between bytes
    task automatic send(input logic [7:0] f[$], input int gap);
        int g;
        foreach (f[i]) begin
            rx_data = f[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            if (i != f.size() - 1)
                repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic status(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_error));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
        check({tag, "_pending"}, 32'(wq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [7:0] f[$], input int gap,
                       input string tag);
        model(f);
        send(f, gap);
        status(tag);
    endtask

    logic [7:0] f1[$] = {8'hA5, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00,
                         8'h03, 8'h20, 8'h1C, 8'h00, 8'h00, 8'h35};

    initial begin
        logic [7:0] f[$];
        logic [7:0] part[$];
        #23 reset = 1'b1;
        @(posedge clk); #1;

        @(negedge clk);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", imem_addr, 0);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        @(posedge clk); #1;

        send({8'h00, 8'hFF, 8'h12}, 1);
        @(negedge clk);
        check("idle_addr", imem_addr, 0);
        check("idle_data", imem_wdata, 0);
        check("idle_hold", 32'(cpu_hold), 0);
        check("idle_done", 32'(done), 0);
        check("idle_error", 32'(error), 0);
        @(posedge clk); #1;

        run({8'hA5, 8'h00, 8'h00, 8'h00}, 0, "zero_len");
        run(f1, 1, "t1");

        f = f1;
        f[11] = 8'h34;
        run(f, 0, "bad_chk");
        run(f1, -1, "t1_again");

        run({8'hA5, 8'h01, 8'h2C}, 0, "too_long");
        run({8'hA5, 8'h01, 8'h01}, 1, "len_257");

        send({8'hA5, 8'h00, 8'h01, 8'h08}, 0);
        repeat (TO - 2) @(posedge clk);
        @(negedge clk);
        check("to_early", 32'(error), 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("to_error", 32'(error), 1);
        check("to_hold", 32'(cpu_hold), 1);
        check("to_nowrite", 32'(wq.size()), 0);
        @(posedge clk); #1;
        run(f1, 0, "after_to");

        part = f1[0:5];
        send(part, 0);
        #2 reset = 1'b0;
        #1;
        check("arst_we", 32'(imem_we), 0);
        check("arst_addr", imem_addr, 0);
        check("arst_data", imem_wdata, 0);
        check("arst_hold", 32'(cpu_hold), 0);
        check("arst_done", 32'(done), 0);
        check("arst_error", 32'(error), 0);
        @(posedge clk); #1 reset = 1'b1;
        run(f1, 0, "after_rst");

        for (int k = 0; k < 24; k++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 400)
                                            : $urandom_range(0, 6);
            if (n > 256) f = {8'hA5, 8'(n >> 8), 8'(n)};
            else build(n, $urandom_range(0, 3) == 0, f);
            send({8'(($urandom_range(0, 1) == 0) ? 8'h5A : 8'h00)}, 0);
            run(f, -1, "rand");
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
